// File: rtl/pipe_pkg.sv
// ============================================================================
// Module   : pipe_pkg
// Purpose  : Shared pipeline encodings and constants for the execute stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_pkg;

    localparam int XLEN  = 32;
    localparam int REG_W = 4;

    // PC value carried by bubbles so they are easy to spot in traces
    localparam logic [31:0] c_bubble_pc = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ALU_ADD   = 3'b000,
        ALU_SUB   = 3'b001,
        ALU_AND   = 3'b010,
        ALU_OR    = 3'b011,
        ALU_SLL   = 3'b100,
        ALU_SRL   = 3'b101,
        ALU_SLT   = 3'b110,
        ALU_PASSB = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        SRC_B_FWD  = 2'b00,
        SRC_B_IMM  = 2'b01,
        SRC_B_PC1  = 2'b10,
        SRC_B_ZERO = 2'b11
    } alu_src_e;

    typedef enum logic [1:0] {
        BR_NONE = 2'b00,
        BR_BEQ  = 2'b01,
        BR_BNE  = 2'b10,
        BR_JUMP = 2'b11
    } branch_e;

    typedef struct packed {
        logic mem_read;
        logic mem_write;
        logic wb_data;
        logic reg_write;
        logic data_write;
    } ctrl_t;

endpackage

`default_nettype wire

// File: rtl/alu.sv
// ============================================================================
// Module   : alu
// Purpose  : Combinational integer ALU, modulo 2^XLEN, no flags.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu
    import pipe_pkg::*;
#(
    parameter int XLEN = pipe_pkg::XLEN
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [2:0]      op,
    output logic [XLEN-1:0] result
);

    always_comb begin
        result = '0;
        case (op)
            ALU_ADD:   result = a + b;
            ALU_SUB:   result = a - b;
            ALU_AND:   result = a & b;
            ALU_OR:    result = a | b;
            ALU_SLL:   result = a << b[4:0];
            ALU_SRL:   result = a >> b[4:0];
            ALU_SLT:   result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_PASSB: result = b;
            default:   result = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/ex_stage.sv
// ============================================================================
// Module   : ex_stage
// Purpose  : Execute stage: forwarding, ALU, branch resolve, EX/MEM register.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_stage
    import pipe_pkg::*;
#(
    parameter int XLEN   = pipe_pkg::XLEN,
    parameter int SHADOW = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [2:0]        ALUOp_in,
    input  logic [1:0]        ALUSrc_in,
    input  logic [1:0]        Branch_in,
    input  logic              MemRead_in,
    input  logic              MemWrite_in,
    input  logic              WBdata_in,
    input  logic              RegWrite_in,
    input  logic              Data_write_in,
    input  logic [REG_W-1:0]  Rs_in,
    input  logic [REG_W-1:0]  Rt_in,
    input  logic [REG_W-1:0]  Rd_in,
    input  logic [XLEN-1:0]   BusA_in,
    input  logic [XLEN-1:0]   BusB_in,
    input  logic [XLEN-1:0]   imm_ext_in,
    input  logic [XLEN-1:0]   PC_in,
    input  logic [XLEN-1:0]   BTA_in,
    input  logic              wb_regwrite,
    input  logic [REG_W-1:0]  wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    output logic              mem_valid,
    output logic [XLEN-1:0]   mem_alu_result,
    output logic [XLEN-1:0]   mem_store_data,
    output logic [REG_W-1:0]  mem_rd,
    output logic              mem_MemRead,
    output logic              mem_MemWrite,
    output logic              mem_WBdata,
    output logic              mem_RegWrite,
    output logic              mem_Data_write,
    output logic [XLEN-1:0]   mem_pc,
    output logic              redirect_valid,
    output logic [XLEN-1:0]   redirect_pc
);

    localparam int CNT_W = (SHADOW < 1) ? 1 : $clog2(SHADOW + 1);
    localparam logic [XLEN-1:0] BUBBLE_PC = XLEN'(c_bubble_pc);

    logic              valid_q, valid_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [XLEN-1:0]   store_q, store_d;
    logic [REG_W-1:0]  rd_q, rd_d;
    ctrl_t             ctrl_q, ctrl_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic              redir_valid_q, redir_valid_d;
    logic [XLEN-1:0]   redir_pc_q, redir_pc_d;
    logic [CNT_W-1:0]  squash_q, squash_d;

    logic [XLEN-1:0]   fwd_a, fwd_b, op_b, alu_res;
    logic              exmem_fwd_ok, squashing, eff, taken;
    ctrl_t             ctrl_in;

    // Loads still in EX/MEM have no data yet, so they never forward
    assign exmem_fwd_ok = valid_q & ctrl_q.reg_write & ~ctrl_q.mem_read;
    assign squashing    = (squash_q != '0);
    assign eff          = id_valid & ~squashing & ~flush;
    assign ctrl_in      = '{MemRead_in, MemWrite_in, WBdata_in, RegWrite_in, Data_write_in};

    always_comb begin
        fwd_a = BusA_in;
        if (exmem_fwd_ok && rd_q == Rs_in)       fwd_a = result_q;
        else if (wb_regwrite && wb_rd == Rs_in)  fwd_a = wb_data;

        fwd_b = BusB_in;
        if (exmem_fwd_ok && rd_q == Rt_in)       fwd_b = result_q;
        else if (wb_regwrite && wb_rd == Rt_in)  fwd_b = wb_data;
    end

    always_comb begin
        op_b = fwd_b;
        case (ALUSrc_in)
            SRC_B_FWD:  op_b = fwd_b;
            SRC_B_IMM:  op_b = imm_ext_in;
            SRC_B_PC1:  op_b = PC_in + XLEN'(1);
            SRC_B_ZERO: op_b = '0;
            default:    op_b = fwd_b;
        endcase
    end

    alu #(.XLEN(XLEN)) u_alu (
        .a      (fwd_a),
        .b      (op_b),
        .op     (ALUOp_in),
        .result (alu_res)
    );

    always_comb begin
        taken = 1'b0;
        case (Branch_in)
            BR_BEQ:  taken = (fwd_a == fwd_b);
            BR_BNE:  taken = (fwd_a != fwd_b);
            BR_JUMP: taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        valid_d       = valid_q;
        result_d      = result_q;
        store_d       = store_q;
        rd_d          = rd_q;
        ctrl_d        = ctrl_q;
        pc_d          = pc_q;
        redir_valid_d = redir_valid_q;
        redir_pc_d    = redir_pc_q;
        squash_d      = squash_q;

        // Flush overrides stall
        if (flush || !stall) begin
            if (eff) begin
                valid_d  = 1'b1;
                result_d = alu_res;
                store_d  = fwd_b;
                rd_d     = Rd_in;
                ctrl_d   = ctrl_in;
                pc_d     = PC_in;
            end else begin
                valid_d  = 1'b0;
                result_d = '0;
                store_d  = '0;
                rd_d     = '0;
                ctrl_d   = '0;
                pc_d     = BUBBLE_PC;
            end

            redir_valid_d = eff & taken;
            if (eff && taken) redir_pc_d = BTA_in;

            if (flush)                        squash_d = '0;
            else if (squashing && id_valid)   squash_d = squash_q - CNT_W'(1);
            else if (eff && taken)            squash_d = CNT_W'(SHADOW);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q       <= 1'b0;
            result_q      <= '0;
            store_q       <= '0;
            rd_q          <= '0;
            ctrl_q        <= '0;
            pc_q          <= BUBBLE_PC;
            redir_valid_q <= 1'b0;
            redir_pc_q    <= '0;
            squash_q      <= '0;
        end else begin
            valid_q       <= valid_d;
            result_q      <= result_d;
            store_q       <= store_d;
            rd_q          <= rd_d;
            ctrl_q        <= ctrl_d;
            pc_q          <= pc_d;
            redir_valid_q <= redir_valid_d;
            redir_pc_q    <= redir_pc_d;
            squash_q      <= squash_d;
        end
    end

    assign mem_valid      = valid_q;
    assign mem_alu_result = result_q;
    assign mem_store_data = store_q;
    assign mem_rd         = rd_q;
    assign mem_MemRead    = ctrl_q.mem_read;
    assign mem_MemWrite   = ctrl_q.mem_write;
    assign mem_WBdata     = ctrl_q.wb_data;
    assign mem_RegWrite   = ctrl_q.reg_write;
    assign mem_Data_write = ctrl_q.data_write;
    assign mem_pc         = pc_q;
    assign redirect_valid = redir_valid_q;
    assign redirect_pc    = redir_pc_q;

endmodule

`default_nettype wire
